kypd_emulator: RTL

- Device-side model of the PmodKYPD 4x4 keypad. It answers the column scan of the keypad decoder by pulling the matching row line low while a simulated key is "held".
- Key codes are queued through a valid/ready push interface. Each queued key is pressed for HOLD_CYCLES, then released for GAP_CYCLES.
- Placed on a second PMOD header, looped back to the decoder's header, for hardware self-test without a physical keypad.

---
 rtl/kypd_emulator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/kypd_emulator.sv
// Device-side PmodKYPD model: queued key codes are pressed for HOLD_CYCLES, then released for GAP_CYCLES,
// and the row lines answer the decoder's column scan while a key is held.
module kypd_emulator #(
  parameter int unsigned HOLD_CYCLES = 2_000_000,
  parameter int unsigned GAP_CYCLES  = 2_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       pressed,
  output logic [3:0] cur_key,
  output logic       busy
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pressed_next;
  logic [3:0]    cur_key_next;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop, empty;

  logic [3:0]    col_m, col_s;
  logic [1:0]    key_row, key_col;
  logic [3:0]    row_next;

  assign empty      = (count == '0);
  assign push       = key_valid && key_ready;
  assign pop        = (state == IDLE) && !empty;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  // Key queue; key_ready is registered so a push can never land on a full queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      key_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  // Press/release sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pressed <= 1'b0;
      cur_key <= 4'h0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pressed <= pressed_next;
      cur_key <= cur_key_next;
      busy    <= (count_next != '0) || (state_next != IDLE);
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pressed_next = pressed;
    cur_key_next = cur_key;
    case (state)
      IDLE: begin
        if (pop) begin
          cur_key_next = mem[rd_ptr];
          cnt_next     = CW'(HOLD_CYCLES - 1);
          pressed_next = 1'b1;
          state_next   = PRESS;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          pressed_next = 1'b0;
          cur_key_next = 4'h0;
          cnt_next     = CW'(GAP_CYCLES - 1);
          state_next   = GAP;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Keypad matrix position of the held key
  always_comb begin
    key_row = 2'd0;
    key_col = 2'd0;
    case (cur_key)
      4'h1: begin key_row = 2'd0; key_col = 2'd0; end
      4'h2: begin key_row = 2'd0; key_col = 2'd1; end
      4'h3: begin key_row = 2'd0; key_col = 2'd2; end
      4'hA: begin key_row = 2'd0; key_col = 2'd3; end
      4'h4: begin key_row = 2'd1; key_col = 2'd0; end
      4'h5: begin key_row = 2'd1; key_col = 2'd1; end
      4'h6: begin key_row = 2'd1; key_col = 2'd2; end
      4'hB: begin key_row = 2'd1; key_col = 2'd3; end
      4'h7: begin key_row = 2'd2; key_col = 2'd0; end
      4'h8: begin key_row = 2'd2; key_col = 2'd1; end
      4'h9: begin key_row = 2'd2; key_col = 2'd2; end
      4'hC: begin key_row = 2'd2; key_col = 2'd3; end
      4'h0: begin key_row = 2'd3; key_col = 2'd0; end
      4'hF: begin key_row = 2'd3; key_col = 2'd1; end
      4'hE: begin key_row = 2'd3; key_col = 2'd2; end
      4'hD: begin key_row = 2'd3; key_col = 2'd3; end
      default: begin key_row = 2'd0; key_col = 2'd0; end
    endcase
  end

  always_comb begin
    row_next = 4'hF;
    if (pressed && !col_s[key_col]) row_next[key_row] = 1'b0;
  end

  // col_n is asynchronous to clk: two-flop synchroniser, then registered row response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      row_n <= 4'hF;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
      row_n <= row_next;
    end
  end

endmodule
